alu_test_sequencer: RTL and testbench

ALU_TEST_SEQUENCER -- requirements
Module: alu_test_sequencer

---
 rtl/alu_test_sequencer_if.sv | 8 +
 rtl/alu_test_sequencer.sv | 86 ++++++++
 tb/tb_alu_test_sequencer.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/alu_test_sequencer_if.sv
// alu_test_sequencer_if: vector/result handshake between sequencer and ALU under test
interface alu_test_sequencer_if #(parameter int WIDTH = 7);
  logic [WIDTH-1:0] A, B, res;
  logic [1:0] OP;
  logic vec_valid, vec_ready, res_valid, res_zero;
  modport master (output A, B, OP, vec_valid, input vec_ready, res_valid, res, res_zero);
  modport slave (input A, B, OP, vec_valid, output vec_ready, res_valid, res, res_zero);
endinterface

// File: rtl/alu_test_sequencer.sv
// alu_test_sequencer: issues a fixed vector set to an ALU and scores its results
module alu_test_sequencer #(
  parameter int WIDTH = 7,
  parameter int NUM_VEC = 4,
  parameter logic [WIDTH-1:0] SEED = 7'b1010101,
  parameter int TIMEOUT = 16
) (
  input logic clk,
  input logic reset,
  input logic start,
  alu_test_sequencer_if.master bus,
  output logic busy,
  output logic done,
  output logic pass,
  output logic timeout_seen,
  output logic [7:0] err_count,
  output logic [7:0] vec_idx
);
  localparam logic [7:0] LAST = 8'(NUM_VEC - 1);
  localparam int TW = $clog2(TIMEOUT + 1);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;
  state_t st, nxt;
  logic [WIDTH-1:0] a_v, b_v, exp_v, exp_q;
  logic [1:0] op_v;
  logic [TW-1:0] timer;
  logic [7:0] err_n;
  logic is_last, act, got, tmo, adv, bad;
  function automatic logic [WIDTH-1:0] rotl(input logic [WIDTH-1:0] v, input int n);
    return (v << n) | (v >> (WIDTH - n));
  endfunction
  assign is_last = vec_idx == LAST;
  assign a_v = is_last ? WIDTH'(1) : rotl(SEED, int'(vec_idx) % WIDTH) ^ WIDTH'(vec_idx);
  assign b_v = is_last ? WIDTH'(WIDTH) : WIDTH'(int'(vec_idx) % (WIDTH + 1));
  assign op_v = is_last ? 2'd1 : vec_idx[1:0];
  // shifts by >= WIDTH already yield zero, matching the expected-value rule
  assign exp_v = op_v == 2'd0 ? ~a_v : op_v == 2'd1 ? a_v >> b_v : op_v == 2'd2 ? a_v << b_v : a_v & b_v;
  assign act = st == ISSUE || st == WAIT;
  assign busy = act;
  assign done = st == DONE;
  assign bus.vec_valid = st == ISSUE;
  assign bus.A = act ? a_v : '0;
  assign bus.B = act ? b_v : '0;
  assign bus.OP = act ? op_v : '0;
  assign got = st == WAIT && bus.res_valid;
  assign tmo = st == WAIT && !bus.res_valid && timer == TW'(TIMEOUT - 1);
  assign adv = got || tmo;
  assign bad = tmo || (got && (bus.res != exp_q || bus.res_zero != (exp_q == '0)));
  assign err_n = bad && err_count != 8'hFF ? err_count + 8'd1 : err_count;
  always_comb begin
    nxt = st;
    case (st)
      IDLE: nxt = start ? ISSUE : IDLE;
      ISSUE: nxt = bus.vec_ready ? WAIT : ISSUE;
      WAIT: nxt = adv ? (is_last ? DONE : ISSUE) : WAIT;
      default: nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      st <= IDLE;
      exp_q <= '0;
      timer <= '0;
      pass <= 1'b0;
      timeout_seen <= 1'b0;
      err_count <= '0;
      vec_idx <= '0;
    end else begin
      st <= nxt;
      err_count <= err_n;
      if (st == IDLE && start) begin
        err_count <= '0;
        vec_idx <= '0;
        timeout_seen <= 1'b0;
        pass <= 1'b0;
      end
      if (st == ISSUE && bus.vec_ready) begin
        exp_q <= exp_v;
        timer <= '0;
      end
      if (st == WAIT) timer <= timer + TW'(1);
      if (tmo) timeout_seen <= 1'b1;
      if (adv && is_last) pass <= err_n == 8'd0;
      else if (adv) vec_idx <= vec_idx + 8'd1;
    end
  end
endmodule

// File: tb/tb_alu_test_sequencer.sv
// tb_alu_test_sequencer: directed and randomized runs against an arithmetic reference model
module tb_alu_test_sequencer;
  localparam int W = 7, N = 4, T = 16;
  localparam logic [6:0] S = 7'b1010101;
  logic clk = 0, reset = 1, start = 0;
  logic busy, done, pass, timeout_seen;
  logic [7:0] err_count, vec_idx;
  int n_chk = 0, n_fail = 0;
  alu_test_sequencer_if #(.WIDTH(W)) bus ();
  alu_test_sequencer #(.WIDTH(W), .NUM_VEC(N), .SEED(S), .TIMEOUT(T)) dut (
    .clk(clk), .reset(reset), .start(start), .bus(bus),
    .busy(busy), .done(done), .pass(pass), .timeout_seen(timeout_seen),
    .err_count(err_count), .vec_idx(vec_idx)
  );
  always #5 clk = ~clk;
  initial begin
    #400000;
    $error("FAIL watchdog: observed no finish, expected finish");
    $fatal(1, "watchdog");
  end
  function automatic void ref_vec(input int i, output int a, output int b, output int op, output int r);
    int s = int'(S);
    int k = i % W;
    if (i == N - 1) begin
      a = 1; op = 1; b = W;
    end else begin
      a = (((s * 2**k) % 2**W) + s / 2**(W - k)) ^ (i % 2**W);
      op = i % 4;
      b = i % (W + 1);
    end
    case (op)
      0: r = 2**W - 1 - a;
      1: r = b >= W ? 0 : a / 2**b;
      2: r = (a * 2**b) % 2**W;
      default: r = a & b;
    endcase
  endfunction
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask
  task automatic tick;
    @(negedge clk);
  endtask
  task automatic chk_zero(input string tag);
    chk({tag, "_vec_valid"}, 32'(bus.vec_valid), 0);
    chk({tag, "_A"}, 32'(bus.A), 0);
    chk({tag, "_B"}, 32'(bus.B), 0);
    chk({tag, "_OP"}, 32'(bus.OP), 0);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_done"}, 32'(done), 0);
    chk({tag, "_pass"}, 32'(pass), 0);
    chk({tag, "_timeout_seen"}, 32'(timeout_seen), 0);
    chk({tag, "_err_count"}, 32'(err_count), 0);
    chk({tag, "_vec_idx"}, 32'(vec_idx), 0);
  endtask
  task automatic run(input int slow_idx, input int slow, input int silent_idx, input int bad_idx,
                     input int abort_idx, input bit rnd);
    int a, b, op, r, d, lat;
    int errs = 0;
    start = 1;
    tick;
    start = 0;
    for (int i = 0; i < N; i++) begin
      ref_vec(i, a, b, op, r);
      for (int k = 0; k < 4 && !bus.vec_valid; k++) tick;
      chk("vec_valid", 32'(bus.vec_valid), 1);
      chk("vec_idx", 32'(vec_idx), i);
      chk("A", 32'(bus.A), a);
      chk("B", 32'(bus.B), b);
      chk("OP", 32'(bus.OP), op);
      chk("busy", 32'(busy), 1);
      d = rnd ? int'($urandom_range(0, 3)) : (i == slow_idx ? slow : 0);
      repeat (d) begin
        start = rnd && $urandom_range(0, 1) == 1;
        tick;
        chk("A_stable", 32'(bus.A), a);
        chk("B_stable", 32'(bus.B), b);
        chk("OP_stable", 32'(bus.OP), op);
        chk("valid_stable", 32'(bus.vec_valid), 1);
      end
      bus.vec_ready = 1;
      bus.res_valid = rnd && $urandom_range(0, 1) == 1;
      bus.res = 7'(~r);
      bus.res_zero = r != 0;
      tick;
      bus.vec_ready = 0;
      bus.res_valid = 0;
      start = 0;
      chk("wait_valid", 32'(bus.vec_valid), 0);
      chk("A_held", 32'(bus.A), a);
      chk("OP_held", 32'(bus.OP), op);
      if (i == abort_idx) begin
        reset = 1;
        #1;
        chk_zero("abort");
        tick;
        reset = 0;
        chk_zero("abort_hold");
        tick;
        chk("abort_no_done", 32'(done), 0);
        return;
      end
      if (i == silent_idx) begin
        repeat (T - 1) tick;
        chk("timeout_early", 32'(timeout_seen), 0);
        chk("timeout_still_wait", 32'(bus.vec_valid), 0);
        tick;
        chk("timeout_seen", 32'(timeout_seen), 1);
        errs++;
      end else begin
        lat = rnd ? int'($urandom_range(0, 3)) : 0;
        repeat (lat) tick;
        bus.res_valid = 1;
        bus.res = 7'(r);
        bus.res_zero = r == 0;
        if (i == bad_idx) begin
          bus.res = '0;
          errs++;
        end else if (rnd && $urandom_range(0, 3) == 0) begin
          errs++;
          if ($urandom_range(0, 1) == 1) bus.res = 7'(r) ^ 7'($urandom_range(1, 127));
          else bus.res_zero = r != 0;
        end
        tick;
        bus.res_valid = 0;
      end
    end
    chk("done", 32'(done), 1);
    chk("pass", 32'(pass), 32'(errs == 0));
    chk("err_count", 32'(err_count), errs);
    chk("done_busy", 32'(busy), 0);
    chk("done_A", 32'(bus.A), 0);
    tick;
    chk("done_once", 32'(done), 0);
    chk("pass_held", 32'(pass), 32'(errs == 0));
    chk("idle_B", 32'(bus.B), 0);
    chk("idle_OP", 32'(bus.OP), 0);
  endtask
  initial begin
    bus.vec_ready = 0;
    bus.res_valid = 0;
    bus.res = '0;
    bus.res_zero = 0;
    tick;
    tick;
    chk_zero("reset");
    reset = 0;
    tick;
    run(-1, 0, -1, -1, -1, 0);
    run(-1, 0, -1, 1, -1, 0);
    bus.res_valid = 1;
    bus.res = 7'h55;
    start = 0;
    tick;
    bus.res_valid = 0;
    tick;
    chk("idle_res_err", 32'(err_count), 1);
    chk("idle_res_idx", 32'(vec_idx), N - 1);
    chk("idle_busy", 32'(busy), 0);
    run(2, 5, -1, -1, -1, 0);
    run(-1, 0, 0, -1, -1, 0);
    run(-1, 0, -1, -1, 2, 0);
    run(-1, 0, -1, -1, -1, 0);
    repeat (25) run(-1, 0, int'($urandom_range(0, 7)), -1, -1, 1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
